text_cursor_writer: RTL

TEXT_CURSOR_WRITER -- requirements
Module: text_cursor_writer

---
 rtl/text_cursor_writer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/text_cursor_writer.sv
// Text-mode cursor writer: turns a byte stream into character-cell RAM writes,
// with cursor tracking, control codes, screen clear and optional scroll-up.
module text_cursor_writer #(
  parameter int unsigned COLUMNS    = 80,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter bit          SCROLL_EN  = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            Data_i,
  input  logic                  Valid_i,
  output logic                  Ready_o,
  output logic [ADDR_WIDTH-1:0] RamAddr_o,
  output logic [15:0]           RamWrData_o,
  output logic                  RamWrEn_o,
  input  logic [15:0]           RamRdData_i,
  output logic [ADDR_WIDTH-1:0] CursorCol_o,
  output logic [ADDR_WIDTH-1:0] CursorRow_o
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam logic [AW-1:0] ColsA      = AW'(COLUMNS);
  localparam logic [AW-1:0] LastColA   = AW'(COLUMNS - 1);
  localparam logic [AW-1:0] LastRowA   = AW'(ROWS - 1);
  localparam logic [AW-1:0] LastCellA  = AW'(COLUMNS * ROWS - 1);
  localparam logic [AW-1:0] LastSrcA   = AW'((ROWS - 1) * COLUMNS - 1);
  localparam logic [7:0]    CodeBs     = 8'h08;
  localparam logic [7:0]    CodeLf     = 8'h0A;
  localparam logic [7:0]    CodeFf     = 8'h0C;
  localparam logic [7:0]    CodeCr     = 8'h0D;
  localparam logic [7:0]    Space      = 8'h20;
  localparam logic [7:0]    AttrReset  = 8'h70;

  typedef enum logic [2:0] {IDLE, WRITE, SCROLL_RD, SCROLL_WR, FILL} state_t;

  state_t         stateQ, stateNext;
  logic [AW-1:0]  colQ, colNext, rowQ, rowNext;
  logic [AW-1:0]  pendColQ, pendColNext, pendRowQ, pendRowNext;
  logic           pendScrollQ, pendScrollNext;
  logic [7:0]     attrQ, attrNext;
  logic [AW-1:0]  addrQ, addrNext;
  logic [15:0]    wrDataQ, wrDataNext;
  logic           wrEnQ, wrEnNext;
  logic           readyQ;
  logic [AW-1:0]  cursorAddr, pendAddr, nlRow;
  logic           nlScroll;

  // Cell addresses and the outcome of a newline from the current row
  always_comb begin
    cursorAddr = rowQ * ColsA + colQ;
    pendAddr   = pendRowQ * ColsA + pendColQ;
    nlScroll   = SCROLL_EN && (rowQ == LastRowA);
    if (rowQ == LastRowA) nlRow = SCROLL_EN ? rowQ : '0;
    else                  nlRow = rowQ + AW'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    stateNext      = stateQ;
    colNext        = colQ;
    rowNext        = rowQ;
    pendColNext    = pendColQ;
    pendRowNext    = pendRowQ;
    pendScrollNext = pendScrollQ;
    attrNext       = attrQ;
    addrNext       = addrQ;
    wrDataNext     = wrDataQ;
    wrEnNext       = 1'b0;
    case (stateQ)
      IDLE: begin
        addrNext = cursorAddr;
        if (Valid_i) begin
          stateNext      = WRITE;
          pendColNext    = colQ;
          pendRowNext    = rowQ;
          pendScrollNext = 1'b0;
          if (Data_i[7]) begin
            attrNext = {1'b0, Data_i[6:0]};
          end else begin
            case (Data_i)
              CodeCr: pendColNext = '0;
              CodeLf: begin
                pendColNext    = '0;
                pendRowNext    = nlRow;
                pendScrollNext = nlScroll;
              end
              CodeBs: begin
                // Stepping back from column 0 lands on the previous row's last cell,
                // which is still cursorAddr-1 in linear addressing.
                if (colQ != '0 || rowQ != '0) begin
                  wrEnNext   = 1'b1;
                  addrNext   = cursorAddr - AW'(1);
                  wrDataNext = {attrQ, Space};
                  if (colQ != '0) begin
                    pendColNext = colQ - AW'(1);
                  end else begin
                    pendColNext = LastColA;
                    pendRowNext = rowQ - AW'(1);
                  end
                end
              end
              CodeFf: begin
                stateNext   = FILL;
                addrNext    = '0;
                wrEnNext    = 1'b1;
                wrDataNext  = {attrQ, Space};
                pendColNext = '0;
                pendRowNext = '0;
              end
              default: begin
                wrEnNext   = 1'b1;
                wrDataNext = {attrQ, Data_i};
                if (colQ == LastColA) begin
                  pendColNext    = '0;
                  pendRowNext    = nlRow;
                  pendScrollNext = nlScroll;
                end else begin
                  pendColNext = colQ + AW'(1);
                end
              end
            endcase
          end
        end
      end
      WRITE: begin
        if (pendScrollQ) begin
          stateNext = SCROLL_RD;
          addrNext  = ColsA;
        end else begin
          stateNext = IDLE;
          colNext   = pendColQ;
          rowNext   = pendRowQ;
          addrNext  = pendAddr;
        end
      end
      SCROLL_RD: begin
        stateNext = SCROLL_WR;
        addrNext  = addrQ - ColsA;
        wrEnNext  = 1'b1;
      end
      SCROLL_WR: begin
        if (addrQ == LastSrcA) begin
          stateNext  = FILL;
          addrNext   = addrQ + AW'(1);
          wrEnNext   = 1'b1;
          wrDataNext = {attrQ, Space};
        end else begin
          stateNext = SCROLL_RD;
          addrNext  = addrQ + AW'(1) + ColsA;
        end
      end
      FILL: begin
        if (addrQ == LastCellA) begin
          stateNext = IDLE;
          colNext   = pendColQ;
          rowNext   = pendRowQ;
          addrNext  = pendAddr;
        end else begin
          addrNext = addrQ + AW'(1);
          wrEnNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stateQ      <= IDLE;
      colQ        <= '0;
      rowQ        <= '0;
      pendColQ    <= '0;
      pendRowQ    <= '0;
      pendScrollQ <= 1'b0;
      attrQ       <= AttrReset;
      addrQ       <= '0;
      wrDataQ     <= '0;
      wrEnQ       <= 1'b0;
      readyQ      <= 1'b1;
    end else begin
      stateQ      <= stateNext;
      colQ        <= colNext;
      rowQ        <= rowNext;
      pendColQ    <= pendColNext;
      pendRowQ    <= pendRowNext;
      pendScrollQ <= pendScrollNext;
      attrQ       <= attrNext;
      addrQ       <= addrNext;
      wrDataQ     <= wrDataNext;
      wrEnQ       <= wrEnNext;
      readyQ      <= (stateNext == IDLE);
    end
  end

  // Scroll copies read data straight through: it only arrives in the write cycle
  assign RamWrData_o = (stateQ == SCROLL_WR) ? RamRdData_i : wrDataQ;
  assign RamAddr_o   = addrQ;
  assign RamWrEn_o   = wrEnQ;
  assign Ready_o     = readyQ;
  assign CursorCol_o = colQ;
  assign CursorRow_o = rowQ;

endmodule
